// File: rtl/mul_pkg.sv
// Shared types, widths and the sequence-number kill predicate for the
// pipelined multiplier.
package mul_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_STAGES = 4;
  localparam int SQN_W      = 7;
  localparam int TAG_W      = 7;
  localparam int BITS       = XLEN / NUM_STAGES;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqN;
  } mul_branch_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  srcA;
    logic [XLEN-1:0]  srcB;
    mul_op_t          op;
    logic [TAG_W-1:0] tagDst;
    logic [4:0]       nmDst;
    logic [SQN_W-1:0] sqN;
    logic [31:0]      pc;
  } mul_uop_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tagDst;
    logic [4:0]       nmDst;
    logic [SQN_W-1:0] sqN;
    logic [2:0]       flags;
    logic             doNotCommit;
  } mul_res_t;

  // One in-flight op: conditioned operands plus the running partial sum.
  typedef struct packed {
    logic              valid;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              neg;
    mul_op_t           op;
    logic [TAG_W-1:0]  tagDst;
    logic [4:0]        nmDst;
    logic [SQN_W-1:0]  sqN;
  } mul_stage_t;

  // True when s is the same age as or older than ref_sqn (wrap-around compare).
  function automatic logic sqn_older_eq(input logic [SQN_W-1:0] s,
                                        input logic [SQN_W-1:0] ref_sqn);
    logic [SQN_W-1:0] d;
    d = s - ref_sqn;
    return $signed(d) <= 0;
  endfunction

  function automatic logic is_killed(input logic [SQN_W-1:0] s,
                                     input mul_branch_t br);
    return br.taken && !sqn_older_eq(s, br.sqN);
  endfunction

endpackage

// File: rtl/multiply_pipelined_if.sv
// Issue/result bundle between the execute cluster and the multiplier.
interface multiply_pipelined_if;
  import mul_pkg::*;

  // Handshake: a uop transfers on a clk edge when en && IN_uop.valid &&
  // !IN_stall; OUT_busy mirrors IN_stall and issue must hold off while it is
  // high. OUT_uop transfers on any edge where OUT_uop.valid && !IN_stall, and
  // is held unchanged (apart from flushes) while IN_stall is high.
  logic        en;
  logic        IN_stall;
  logic        OUT_busy;
  mul_branch_t IN_branch;
  mul_uop_t    IN_uop;
  mul_res_t    OUT_uop;

  modport master (
    output en, IN_stall, IN_branch, IN_uop,
    input  OUT_busy, OUT_uop
  );

  modport slave (
    input  en, IN_stall, IN_branch, IN_uop,
    output OUT_busy, OUT_uop
  );
endinterface

// File: rtl/mul_stage.sv
// One accumulation stage: adds the partial product of multiplier chunk STAGE
// and carries valid through stall/flush.
module mul_stage
  import mul_pkg::*;
#(
  parameter int STAGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  mul_branch_t branch,
  input  mul_stage_t  prev,
  output mul_stage_t  cur,
  output logic        killed
);

  logic [XLEN+BITS-1:0] pp;
  logic [2*XLEN-1:0]    pp_sh;

  always_comb begin
    pp    = {{BITS{1'b0}}, prev.a} * {{XLEN{1'b0}}, prev.b[STAGE*BITS +: BITS]};
    pp_sh = {{(XLEN-BITS){1'b0}}, pp} << (STAGE*BITS);
  end

  assign killed = cur.valid && is_killed(cur.sqN, branch);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (stall) begin
      cur.valid <= cur.valid && !is_killed(cur.sqN, branch);
    end else begin
      cur       <= prev;
      cur.valid <= prev.valid && !is_killed(prev.sqN, branch);
      cur.acc   <= prev.acc + pp_sh;
    end
  end

endmodule

// File: rtl/multiply_pipelined.sv
// Fully pipelined XLEN x XLEN multiplier (MUL/MULH/MULHSU/MULHU) with flush
// and backpressure. Optional perf counters under MUL_PERF_CNT_EN.
module multiply_pipelined
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  multiply_pipelined_if.slave bus
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0] OUT_perfAccepted,
  output logic [31:0] OUT_perfFlushed
`endif
);

  logic                 accept;
  logic                 sign_a, sign_b, op_neg;
  logic [XLEN-1:0]      abs_a, abs_b, op_a, op_b;
  logic [XLEN+BITS-1:0] pp0;
  mul_stage_t           p0_q;
  mul_stage_t           p [NUM_STAGES];
  logic [NUM_STAGES-1:0] p_kill;
  mul_stage_t           last;
  logic [2*XLEN-1:0]    prod;
  logic [XLEN-1:0]      res_word;
  mul_res_t             res_q;
  logic                 res_kill;

  assign bus.OUT_busy = bus.IN_stall;
  assign accept = bus.en && bus.IN_uop.valid && !bus.IN_stall &&
                  !is_killed(bus.IN_uop.sqN, bus.IN_branch);

  // Signed forms multiply magnitudes and fix the sign after the last stage.
  always_comb begin
    sign_a = bus.IN_uop.srcA[XLEN-1];
    sign_b = bus.IN_uop.srcB[XLEN-1];
    abs_a  = sign_a ? -bus.IN_uop.srcA : bus.IN_uop.srcA;
    abs_b  = sign_b ? -bus.IN_uop.srcB : bus.IN_uop.srcB;
    op_a   = bus.IN_uop.srcA;
    op_b   = bus.IN_uop.srcB;
    op_neg = 1'b0;
    case (bus.IN_uop.op)
      MULH: begin
        op_a   = abs_a;
        op_b   = abs_b;
        op_neg = sign_a ^ sign_b;
      end
      MULHSU: begin
        op_a   = abs_a;
        op_neg = sign_a;
      end
      default: ;
    endcase
    pp0 = {{BITS{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b[BITS-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= '0;
    end else if (bus.IN_stall) begin
      p0_q.valid <= p0_q.valid && !is_killed(p0_q.sqN, bus.IN_branch);
    end else begin
      p0_q.valid <= accept;
      if (accept) begin
        p0_q.acc    <= {{(XLEN-BITS){1'b0}}, pp0};
        p0_q.a      <= op_a;
        p0_q.b      <= op_b;
        p0_q.neg    <= op_neg;
        p0_q.op     <= bus.IN_uop.op;
        p0_q.tagDst <= bus.IN_uop.tagDst;
        p0_q.nmDst  <= bus.IN_uop.nmDst;
        p0_q.sqN    <= bus.IN_uop.sqN;
      end
    end
  end

  assign p[0]      = p0_q;
  assign p_kill[0] = p0_q.valid && is_killed(p0_q.sqN, bus.IN_branch);

  for (genvar g = 1; g < NUM_STAGES; g++) begin : g_stage
    mul_stage #(.STAGE(g)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .stall  (bus.IN_stall),
      .branch (bus.IN_branch),
      .prev   (p[g-1]),
      .cur    (p[g]),
      .killed (p_kill[g])
    );
  end

  assign last = p[NUM_STAGES-1];

  always_comb begin
    prod     = last.neg ? -last.acc : last.acc;
    res_word = (last.op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // The result bus samples late, so a held result is still flushable.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (bus.IN_stall) begin
      res_q.valid <= res_q.valid && !is_killed(res_q.sqN, bus.IN_branch);
    end else begin
      res_q.valid       <= last.valid && !is_killed(last.sqN, bus.IN_branch);
      res_q.result      <= res_word;
      res_q.tagDst      <= last.tagDst;
      res_q.nmDst       <= last.nmDst;
      res_q.sqN         <= last.sqN;
      res_q.flags       <= 3'b000;
      res_q.doNotCommit <= 1'b0;
    end
  end

  assign res_kill    = res_q.valid && is_killed(res_q.sqN, bus.IN_branch);
  assign bus.OUT_uop = res_q;

`ifdef MUL_PERF_CNT_EN
  logic [31:0] kill_cnt;

  always_comb begin
    kill_cnt = 32'(res_kill);
    for (int k = 0; k < NUM_STAGES; k++) kill_cnt = kill_cnt + 32'(p_kill[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_perfAccepted <= '0;
      OUT_perfFlushed  <= '0;
    end else begin
      OUT_perfAccepted <= OUT_perfAccepted + 32'(accept);
      OUT_perfFlushed  <= OUT_perfFlushed + kill_cnt;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.IN_uop.pc, last.a, last.b};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.IN_uop.pc, last.a, last.b, p_kill, res_kill};
`endif

endmodule

// File: tb/tb_multiply_pipelined.sv
// Bench for multiply_pipelined: directed table, multi-cycle flush/stall/reset
// sequences and random ops checked against a 64-bit arithmetic model.
module tb_multiply_pipelined;
  import mul_pkg::*;

  localparam int W = 3 + 1 + 5 + TAG_W + SQN_W + XLEN;

  typedef struct {
    mul_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  logic [SQN_W-1:0] last_out_sqn = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] keep_q[$];

  multiply_pipelined_if bus();

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_acc, perf_fl;
  multiply_pipelined dut (
    .clk(clk), .rst(rst), .bus(bus),
    .OUT_perfAccepted(perf_acc), .OUT_perfFlushed(perf_fl)
  );
`else
  multiply_pipelined dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic sqn_newer(input logic [SQN_W-1:0] s,
                                     input logic [SQN_W-1:0] b);
    int d;
    d = (int'(s) - int'(b)) & ((1 << SQN_W) - 1);
    return (d >= 1) && (d < (1 << (SQN_W - 1)));
  endfunction

  function automatic logic [XLEN-1:0] ref_mul(input mul_op_t op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea, eb, pr;
    logic sa, sb;
    sa = (op == MULH || op == MULHSU) ? a[XLEN-1] : 1'b0;
    sb = (op == MULH) ? b[XLEN-1] : 1'b0;
    ea = {{XLEN{sa}}, a};
    eb = {{XLEN{sb}}, b};
    pr = ea * eb;
    return (op == MUL) ? pr[XLEN-1:0] : pr[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return XLEN'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input mul_op_t op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [SQN_W-1:0] sqn,
                       input logic [XLEN-1:0] exp_res);
    logic [TAG_W-1:0] tag;
    logic [4:0]       nm;
    tag = TAG_W'($urandom);
    nm  = 5'($urandom);
    bus.en            = 1'b1;
    bus.IN_uop.valid  = 1'b1;
    bus.IN_uop.srcA   = a;
    bus.IN_uop.srcB   = b;
    bus.IN_uop.op     = op;
    bus.IN_uop.tagDst = tag;
    bus.IN_uop.nmDst  = nm;
    bus.IN_uop.sqN    = sqn;
    bus.IN_uop.pc     = $urandom;
    exp_q.push_back({4'b0000, nm, tag, sqn, exp_res});
    tick(1);
    bus.en           = 1'b0;
    bus.IN_uop.valid = 1'b0;
  endtask

  task automatic branch_pulse(input logic [SQN_W-1:0] sqn);
    bus.IN_branch.taken = 1'b1;
    bus.IN_branch.sqN   = sqn;
    tick(1);
    bus.IN_branch.taken = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // A result transfers when valid, not stalled and not flushed this cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.OUT_uop.valid && !bus.IN_stall &&
          !(bus.IN_branch.taken && sqn_newer(bus.OUT_uop.sqN, bus.IN_branch.sqN))) begin
        out_cnt++;
        last_out_sqn = bus.OUT_uop.sqN;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual sqN=%0d result=%0h required none",
                   bus.OUT_uop.sqN, bus.OUT_uop.result);
        end else begin
          check("scoreboard",
                64'({bus.OUT_uop.flags, bus.OUT_uop.doNotCommit, bus.OUT_uop.nmDst,
                     bus.OUT_uop.tagDst, bus.OUT_uop.sqN, bus.OUT_uop.result}),
                64'(exp_q.pop_front()));
        end
      end
      if (bus.IN_branch.taken) begin
        keep_q.delete();
        foreach (exp_q[i])
          if (!sqn_newer(exp_q[i][XLEN +: SQN_W], bus.IN_branch.sqN))
            keep_q.push_back(exp_q[i]);
        exp_q = keep_q;
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    vec_t vecs[14];
    logic [SQN_W-1:0] sqn;
    mul_res_t held;
    int lat;

    vecs[0]  = '{MUL,    32'h0000_1234, 32'h0000_5678, 32'h0626_0060};
    vecs[1]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[7]  = '{MULH,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[8]  = '{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[10] = '{MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[11] = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[12] = '{MULH,   32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[13] = '{MULHSU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};

    bus.en = 1'b0;
    bus.IN_stall = 1'b0;
    bus.IN_branch = '0;
    bus.IN_uop = '0;

    tick(3);
    check("reset_valid", 64'(bus.OUT_uop.valid), 64'd0);
    check("reset_result", 64'(bus.OUT_uop.result), 64'd0);
    check("busy_idle", 64'(bus.OUT_busy), 64'd0);
    rst = 1'b0;
    tick(1);

    sqn = 7'd0;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, sqn, vecs[i].exp);
      sqn++;
      lat = 0;
      while (!bus.OUT_uop.valid && lat < 12) begin
        tick(1);
        lat++;
      end
      check("latency", 64'(lat), 64'(NUM_STAGES));
      check("table_result", 64'(bus.OUT_uop.result), 64'(vecs[i].exp));
      tick(1);
      check("one_cycle_valid", 64'(bus.OUT_uop.valid), 64'd0);
    end

    // back-to-back issue, in-order results on consecutive cycles
    for (int s = 10; s < 15; s++)
      issue(MUL, XLEN'(s), 32'd3, SQN_W'(s), XLEN'(s * 3));
    lat = 0;
    while (!bus.OUT_uop.valid && lat < 12) begin
      tick(1);
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      check("b2b_valid", 64'(bus.OUT_uop.valid), 64'd1);
      check("b2b_result", 64'(bus.OUT_uop.result), 64'(30 + 3 * k));
      tick(1);
    end
    check("b2b_end", 64'(bus.OUT_uop.valid), 64'd0);

    // flush of younger ops by a branch at sqN 20
    out_cnt = 0;
    issue(MUL, 32'd20, 32'd2, 7'd20, 32'd40);
    issue(MUL, 32'd21, 32'd2, 7'd21, 32'd42);
    issue(MUL, 32'd22, 32'd2, 7'd22, 32'd44);
    branch_pulse(7'd20);
    tick(8);
    check("flush_count", 64'(out_cnt), 64'd1);
    check("flush_sqn", 64'(last_out_sqn), 64'd20);

    // stall with two ops in flight: outputs frozen, nothing lost or doubled
    out_cnt = 0;
    issue(MUL, 32'd7, 32'd6, 7'd30, 32'd42);
    issue(MUL, 32'd5, 32'd5, 7'd31, 32'd25);
    tick(3);
    check("pre_stall_sqn", 64'(bus.OUT_uop.sqN), 64'd30);
    held = bus.OUT_uop;
    bus.IN_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_busy", 64'(bus.OUT_busy), 64'd1);
      tick(1);
      check("stall_frozen", 64'({bus.OUT_uop.valid, bus.OUT_uop.sqN, bus.OUT_uop.result}),
            64'({held.valid, held.sqN, held.result}));
    end
    bus.IN_stall = 1'b0;
    tick(6);
    check("stall_count", 64'(out_cnt), 64'd2);

    // branch kills a held op during a stall
    out_cnt = 0;
    issue(MUL, 32'd2, 32'd2, 7'd40, 32'd4);
    issue(MUL, 32'd3, 32'd3, 7'd41, 32'd9);
    tick(3);
    bus.IN_stall = 1'b1;
    tick(1);
    branch_pulse(7'd40);
    tick(1);
    bus.IN_stall = 1'b0;
    tick(6);
    check("stall_kill_count", 64'(out_cnt), 64'd1);
    check("stall_kill_sqn", 64'(last_out_sqn), 64'd40);

    // sqN wrap-around: 1 is newer than 126, 125 is older
    out_cnt = 0;
    issue(MUL, 32'd125, 32'd1, 7'd125, 32'd125);
    issue(MUL, 32'd1, 32'd1, 7'd1, 32'd1);
    branch_pulse(7'd126);
    tick(8);
    check("wrap_count", 64'(out_cnt), 64'd1);
    check("wrap_sqn", 64'(last_out_sqn), 64'd125);

    // same-cycle accept and kill: not accepted; equal sqN is not killed
    out_cnt = 0;
    bus.IN_branch.taken = 1'b1;
    bus.IN_branch.sqN   = 7'd49;
    issue(MULHU, 32'd9, 32'd9, 7'd50, 32'd0);
    bus.IN_branch.taken = 1'b0;
    tick(8);
    check("accept_kill_count", 64'(out_cnt), 64'd0);
    bus.IN_branch.taken = 1'b1;
    bus.IN_branch.sqN   = 7'd51;
    issue(MUL, 32'd9, 32'd9, 7'd51, 32'd81);
    bus.IN_branch.taken = 1'b0;
    tick(8);
    check("equal_sqn_count", 64'(out_cnt), 64'd1);

    // reset mid-flight drops everything
    issue(MUL, 32'd1, 32'd1, 7'd60, 32'd1);
    issue(MUL, 32'd2, 32'd1, 7'd61, 32'd2);
    issue(MUL, 32'd3, 32'd1, 7'd62, 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    out_cnt = 0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      lat += int'(bus.OUT_uop.valid);
      tick(1);
    end
    check("reset_mid_valid", 64'(lat), 64'd0);
    check("reset_mid_count", 64'(out_cnt), 64'd0);

    // randomized traffic with stalls against the arithmetic model
    sqn = 7'd70;
    for (int c = 0; c < 300; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bus.IN_stall = 1'b1;
        tick(1);
      end else begin
        bus.IN_stall = 1'b0;
        if (r >= 4) begin
          mul_op_t op;
          logic [XLEN-1:0] a, b;
          op = mul_op_t'($urandom_range(0, 3));
          a  = pick_operand();
          b  = pick_operand();
          issue(op, a, b, sqn, ref_mul(op, a, b));
          sqn++;
        end else begin
          tick(1);
        end
      end
    end
    bus.IN_stall = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
